// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The zero/overflow flag signals exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_subtractor_if #(
   parameter int NUMBITS = 16
);
   logic [NUMBITS-1:0] A;
   logic [NUMBITS-1:0] B;
   logic               borrowin;
   logic               in_valid;
   logic               in_ready;
   logic [NUMBITS-1:0] result;
   logic               borrowout;
   logic               out_valid;
   logic               out_ready;
`ifdef SERIAL_SUB_FLAGS_EN
   logic               zero;
   logic               overflow;
`endif

   modport master (
      output A, B, borrowin, in_valid, out_ready,
      input  in_ready, result, borrowout, out_valid
`ifdef SERIAL_SUB_FLAGS_EN
      , input zero, overflow
`endif
   );

   modport slave (
      input  A, B, borrowin, in_valid, out_ready,
      output in_ready, result, borrowout, out_valid
`ifdef SERIAL_SUB_FLAGS_EN
      , output zero, overflow
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: result = A - B - borrowin, one bit per clock, LSB first.
// Optional zero/overflow flag outputs are enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_subtractor #(
   parameter int NUMBITS = 16
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(NUMBITS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUMBITS-1:0] r_a;
   logic [NUMBITS-1:0] r_b;
   logic [NUMBITS-1:0] r_result;
   logic               r_br;
   logic               r_borrowout;
   logic [CW-1:0]      r_cnt;

   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_accept;
   logic               w_last;
   logic               w_d;
   logic               w_br_nxt;
   logic [NUMBITS-1:0] w_result_nxt;

   assign w_accept     = (r_state == IDLE) && bus.in_valid;
   assign w_last       = (r_cnt == LAST_BIT);
   assign w_d          = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_nxt     = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   // Difference bits enter at the MSB so the word is aligned after NUMBITS shifts.
   assign w_result_nxt = {w_d, r_result[NUMBITS-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = BUSY;
         end
         BUSY: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_br        <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_borrowout <= 1'b0;
      end else if (w_accept) begin
         r_a      <= bus.A;
         r_b      <= bus.B;
         r_br     <= bus.borrowin;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (r_state == BUSY) begin
         r_a      <= {1'b0, r_a[NUMBITS-1:1]};
         r_b      <= {1'b0, r_b[NUMBITS-1:1]};
         r_br     <= w_br_nxt;
         r_result <= w_result_nxt;
         // Counter parks at zero after the last bit so it never passes NUMBITS-1.
         r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) r_borrowout <= w_br_nxt;
      end
   end

`ifdef SERIAL_SUB_FLAGS_EN
   logic r_zero;
   logic r_overflow;

   // On the last bit r_a[0]/r_b[0] hold the operand sign bits and w_d is the result sign.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
      end else if ((r_state == BUSY) && w_last) begin
         r_zero     <= (w_result_nxt == '0);
         r_overflow <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
      end
   end

   assign bus.zero     = r_zero;
   assign bus.overflow = r_overflow;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.result    = r_result;
   assign bus.borrowout = r_borrowout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (NUMBITS=16).
// Flag checks are compiled in when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_subtractor;
   localparam int N = 16;

   logic clk;
   logic rst;
   int   checks;
   int   passes;
   int   fails;

   serial_subtractor_if #(.NUMBITS(N)) bus ();

   serial_subtractor #(.NUMBITS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic accept_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic bin);
      @(negedge clk);
      bus.A        = a;
      bus.B        = b;
      bus.borrowin = bin;
      bus.in_valid = 1'b1;
      #1;
      chk({tag, " in_ready"}, bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int cyc;
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, cyc, N);
   endtask

   task automatic check_out(input string tag, input logic [N-1:0] res, input logic bo,
                            input logic z, input logic ov);
      chk({tag, " result"}, bus.result, res);
      chk({tag, " borrowout"}, bus.borrowout, bo);
`ifdef SERIAL_SUB_FLAGS_EN
      chk({tag, " zero"}, bus.zero, z);
      chk({tag, " overflow"}, bus.overflow, ov);
`else
      if (z === ov) begin end
`endif
   endtask

   task automatic handoff(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, " out_valid drop"}, bus.out_valid, 0);
      chk({tag, " in_ready back"}, bus.in_ready, 1);
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic bin, input logic [N-1:0] res, input logic bo,
                         input logic z, input logic ov);
      accept_op(tag, a, b, bin);
      wait_done(tag);
      check_out(tag, res, bo, z, ov);
      handoff(tag);
   endtask

   initial begin
      logic [N-1:0] hold_res;
      logic         hold_bo;
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic         rbin;
      logic [N:0]   e;
      logic [N:0]   expq[$];
      int           acc;
      int           outs;
      int           cyc;

      checks = 0;
      passes = 0;
      fails  = 0;
      rst           = 1'b1;
      bus.A         = '0;
      bus.B         = '0;
      bus.borrowin  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset result", bus.result, 0);
      chk("reset borrowout", bus.borrowout, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op("5-3", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      run_op("0-1", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op("10-10-1", 16'h0010, 16'h0010, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op("8000-1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      run_op("1234-1234", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Backpressure: hold the result while a new request waits at the input.
      accept_op("bp", 16'h0100, 16'h0001, 1'b0);
      wait_done("bp");
      hold_res = bus.result;
      hold_bo  = bus.borrowout;
      chk("bp result", hold_res, 16'h00FF);
      bus.A        = 16'h0003;
      bus.B        = 16'h0007;
      bus.borrowin = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp out_valid held", bus.out_valid, 1);
         chk("bp in_ready low", bus.in_ready, 0);
         chk("bp result stable", bus.result, hold_res);
         chk("bp borrow stable", bus.borrowout, hold_bo);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("bp out_valid drop", bus.out_valid, 0);
      chk("bp in_ready back", bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_done("bp resample");
      check_out("bp resample", 16'hFFFC, 1'b1, 1'b0, 1'b0);
      handoff("bp resample");

      // Reset while bit 7 is being processed.
      accept_op("abort", 16'hABCD, 16'h1234, 1'b1);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort in_ready", bus.in_ready, 1);
      chk("abort out_valid", bus.out_valid, 0);
      chk("abort result", bus.result, 0);
      chk("abort borrowout", bus.borrowout, 0);
      @(negedge clk);
      rst = 1'b0;
      run_op("after abort", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);

      // Streaming with in_valid held high and random consumer backpressure.
      acc  = 0;
      outs = 0;
      cyc  = 0;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      @(negedge clk);
      while (outs < 50 && cyc < 5000) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.in_valid  = (acc < 50);
         bus.A         = ra;
         bus.B         = rb;
         bus.borrowin  = rbin;
         #1;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            if (expq.size() > 0) e = expq.pop_front();
            else e = 'x;
            chk("rand result", bus.result, e[N-1:0]);
            chk("rand borrowout", bus.borrowout, e[N]);
            outs++;
         end
         if (bus.in_valid && bus.in_ready === 1'b1) begin
            expq.push_back({1'b0, ra} - {1'b0, rb} - (N+1)'(rbin));
            acc++;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("rand accepts", acc, 50);
      chk("rand outputs", outs, 50);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
